// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32 execute stage: ALU ops, RV32M funct3,
// forwarding selects and the mul/div sequencer states.
package riscv_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
        MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } muldiv_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_e;

    // Unused encoding 11 falls back to the register file value.
    function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                            input logic [31:0] reg_v,
                                            input logic [31:0] w_v,
                                            input logic [31:0] m_v);
        case (sel)
            FWD_W:   return w_v;
            FWD_M:   return m_v;
            default: return reg_v;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: one shift-add or restoring-subtract step per cycle on
// operand magnitudes, with the sign fix applied when entering DONE.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(ITER);

    md_state_e         state, state_nxt;
    muldiv_op_e        op_q;
    logic [CW-1:0]     count;
    logic              neg_a, neg_b, b_zero;
    logic [XLEN-1:0]   op_b;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   result_q;

    logic              a_signed, b_signed, last_step;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_top;
    logic [XLEN-1:0]   div_diff, quo, rem;
    logic [2*XLEN-1:0] mul_step, div_step, step, prod;
    logic [XLEN-1:0]   final_result;

    assign a_signed  = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    assign b_signed  = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    assign last_step = (count == CW'(ITER - 1));

    // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, op_b} : '0);
        mul_step = {mul_sum, acc[XLEN-1:1]};
        div_top  = acc[2*XLEN-1:XLEN-1];
        div_diff = acc[2*XLEN-2:XLEN-1] - op_b;
        div_step = (div_top >= {1'b0, op_b}) ? {div_diff, acc[XLEN-2:0], 1'b1}
                                             : {acc[2*XLEN-2:XLEN-1], acc[XLEN-2:0], 1'b0};
        step     = op_q[2] ? div_step : mul_step;
        prod     = (neg_a ^ neg_b) ? -step : step;
        quo      = step[XLEN-1:0];
        rem      = step[2*XLEN-1:XLEN];
        case (op_q)
            MD_MUL:                       final_result = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: final_result = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              final_result = b_zero ? '1 : ((neg_a ^ neg_b) ? -quo : quo);
            default:                      final_result = neg_a ? -rem : rem;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start)     state_nxt = MD_BUSY;
            MD_BUSY: if (last_step) state_nxt = MD_DONE;
            default:                state_nxt = MD_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; datapath registers are reset too so an aborted op leaves nothing behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= MD_IDLE;
            op_q     <= MD_MUL;
            count    <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            b_zero   <= 1'b0;
            op_b     <= '0;
            acc      <= '0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == MD_IDLE && start) begin
                op_q   <= muldiv_op_e'(op);
                count  <= '0;
                neg_a  <= a_signed & a[XLEN-1];
                neg_b  <= b_signed & b[XLEN-1];
                b_zero <= (b == '0);
                op_b   <= (b_signed & b[XLEN-1]) ? -b : b;
                acc    <= {{XLEN{1'b0}}, (a_signed & a[XLEN-1]) ? -a : a};
            end else if (state == MD_BUSY) begin
                acc   <= step;
                count <= count + 1'b1;
                if (last_step) result_q <= final_result;
            end
        end
    end

    // Gating with reset_n keeps the stall low while reset is held over an issuing instruction.
    assign busy   = (state == MD_BUSY) || (state == MD_IDLE && start && reset_n);
    assign done   = (state == MD_DONE);
    assign result = result_q;

endmodule

// File: rtl/execute_stage.sv
// RV32 execute stage: operand forwarding, single-cycle ALU, branch/jump
// resolution and the iterative mul/div unit that stalls the front end.
module execute_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [2:0]      ALUControlE,
    input  logic            ALUSrcE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            MulDivE,
    input  logic [2:0]      MulDivOpE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    input  logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] ALUResultE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            PCSrcE,
    output logic            ZeroE,
    output logic            StallMD
);

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result, md_result;
    logic            md_done;

    assign src_a      = fwd_mux(ForwardAE, RD1E, ResultW, ALUResultM);
    assign fwd_b      = fwd_mux(ForwardBE, RD2E, ResultW, ALUResultM);
    assign src_b      = ALUSrcE ? ImmExtE : fwd_b;
    assign WriteDataE = fwd_b;
    assign PCTargetE  = PCE + ImmExtE;

    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            default: alu_result = '0;
        endcase
    end

    // A mul/div instruction never branches, so its ALU-path flags are masked.
    assign ZeroE      = ~MulDivE & (alu_result == '0);
    assign PCSrcE     = ~MulDivE & ((BranchE & ZeroE) | JumpE);
    assign ALUResultE = md_done ? md_result : alu_result;

    muldiv_unit #(
        .XLEN (XLEN),
        .ITER (ITER)
    ) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (MulDivE),
        .op      (MulDivOpE),
        .a       (src_a),
        .b       (fwd_b),
        .busy    (StallMD),
        .done    (md_done),
        .result  (md_result)
    );

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed ALU/branch/forwarding
// vectors plus a scoreboard of mul/div results checked at the DONE cycle.
module tb_execute_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, ResultW, ALUResultM;
    logic [2:0]  ALUControlE, MulDivOpE;
    logic        ALUSrcE, BranchE, JumpE, MulDivE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ALUResultE, WriteDataE, PCTargetE;
    logic        PCSrcE, ZeroE, StallMD;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    execute_stage #(.XLEN(32), .ITER(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .PCE         (PCE),
        .ALUControlE (ALUControlE),
        .ALUSrcE     (ALUSrcE),
        .BranchE     (BranchE),
        .JumpE       (JumpE),
        .MulDivE     (MulDivE),
        .MulDivOpE   (MulDivOpE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .ResultW     (ResultW),
        .ALUResultM  (ALUResultM),
        .ALUResultE  (ALUResultE),
        .WriteDataE  (WriteDataE),
        .PCTargetE   (PCTargetE),
        .PCSrcE      (PCSrcE),
        .ZeroE       (ZeroE),
        .StallMD     (StallMD)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model using 64-bit arithmetic rather than iteration.
    function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    task automatic drive_idle();
        RD1E = '0; RD2E = '0; ImmExtE = '0; PCE = '0; ResultW = '0; ALUResultM = '0;
        ALUControlE = ALU_ADD; MulDivOpE = 3'd0; ALUSrcE = 1'b0; BranchE = 1'b0;
        JumpE = 1'b0; MulDivE = 1'b0; ForwardAE = FWD_REG; ForwardBE = FWD_REG;
    endtask

    task automatic alu_vec(input string tag, input logic [2:0] ctrl, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        @(posedge clk); #1;
        drive_idle();
        ALUControlE = ctrl; RD1E = a; RD2E = b;
        @(negedge clk);
        check(tag, ALUResultE, exp);
        check({tag, "_zero"}, ZeroE, exp == 0);
    endtask

    // Issues one mul/div op and returns at the negedge of its DONE cycle.
    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int stalls;
        @(posedge clk); #1;
        drive_idle();
        RD1E = a; RD2E = b; MulDivE = 1'b1; MulDivOpE = op;
        exp_q.push_back(md_model(op, a, b));
        @(negedge clk);
        stalls = 0;
        while (StallMD && stalls < 100) begin
            stalls++;
            @(posedge clk); #1;
            if (stalls == 1) begin
                RD1E = $urandom; RD2E = $urandom; ResultW = $urandom; ALUResultM = $urandom;
                ForwardAE = FWD_M; ForwardBE = FWD_W;
            end
            @(negedge clk);
        end
        check({tag, "_stall_cycles"}, stalls, 33);
        check({tag, "_result"}, ALUResultE, exp_q.pop_front());
        check({tag, "_zero_masked"}, ZeroE, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_idle();
        reset_n = 1'b0;
        RD1E = 32'd9; RD2E = 32'd4; ALUControlE = ALU_SUB;
        #2;
        check("reset_stall", StallMD, 1'b0);
        check("reset_alu_path", ALUResultE, 32'd5);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Branch taken on equal operands
        @(posedge clk); #1;
        drive_idle();
        RD1E = 32'd5; RD2E = 32'd5; ALUControlE = ALU_SUB; BranchE = 1'b1;
        PCE = 32'h100; ImmExtE = 32'h20;
        @(negedge clk);
        check("beq_result", ALUResultE, 32'd0);
        check("beq_zero", ZeroE, 1'b1);
        check("beq_pcsrc", PCSrcE, 1'b1);
        check("beq_target", PCTargetE, 32'h120);
        @(posedge clk); #1 RD2E = 32'd6;
        @(negedge clk);
        check("bne_pcsrc", PCSrcE, 1'b0);
        @(posedge clk); #1 BranchE = 1'b0; JumpE = 1'b1;
        @(negedge clk);
        check("jal_pcsrc", PCSrcE, 1'b1);

        // Forwarding paths and immediate select
        @(posedge clk); #1;
        drive_idle();
        RD1E = 32'd100; RD2E = 32'd200; ForwardAE = FWD_M; ALUResultM = 32'd7;
        ForwardBE = FWD_W; ResultW = 32'd3;
        @(negedge clk);
        check("fwd_add", ALUResultE, 32'd10);
        check("fwd_store_data", WriteDataE, 32'd3);
        @(posedge clk); #1 ALUSrcE = 1'b1; ImmExtE = 32'd1;
        @(negedge clk);
        check("fwd_imm_add", ALUResultE, 32'd8);
        check("fwd_imm_store_data", WriteDataE, 32'd3);
        @(posedge clk); #1 ForwardAE = 2'b11;
        @(negedge clk);
        check("fwd_enc11", ALUResultE, 32'd101);

        alu_vec("alu_add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1);
        alu_vec("alu_sub_wrap", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF);
        alu_vec("alu_and", ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
        alu_vec("alu_or", ALU_OR, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01);
        alu_vec("alu_slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu_vec("alu_slt_pos", ALU_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0);
        alu_vec("alu_undef", 3'b111, 32'd5, 32'd6, 32'd0);

        // Directed mul/div, back-to-back with no gap
        run_md("mulh", MD_MULH, 32'hFFFF_FFFF, 32'd2);
        run_md("mul", MD_MUL, 32'hFFFF_FFFF, 32'd2);
        alu_vec("after_md_alu", ALU_ADD, 32'd40, 32'd2, 32'd42);
        run_md("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2);
        run_md("rem_neg", MD_REM, 32'hFFFF_FFF9, 32'd2);
        run_md("divu_zero", MD_DIVU, 32'd7, 32'd0);
        run_md("remu_zero", MD_REMU, 32'd7, 32'd0);
        run_md("div_zero_signed", MD_DIV, 32'hFFFF_FFF9, 32'd0);
        run_md("rem_zero_signed", MD_REM, 32'hFFFF_FFF9, 32'd0);
        run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md("mul_b2b", MD_MUL, 32'd1234, 32'd5678);
        run_md("div_b2b", MD_DIV, 32'd1000, 32'hFFFF_FFFD);
        for (int i = 0; i < 6; i++)
            run_md("md_rand", 3'($urandom_range(0, 7)), $urandom, (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom);

        // Reset during BUSY discards the operation
        @(posedge clk); #1;
        drive_idle();
        RD1E = 32'd100; RD2E = 32'd7; MulDivE = 1'b1; MulDivOpE = MD_DIVU;
        repeat (11) @(negedge clk);
        check("rst_mid_busy_stall", StallMD, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_stall_low", StallMD, 1'b0);
        check("rst_mid_alu_path", ALUResultE, 32'd107);
        MulDivE = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        run_md("mul_after_rst", MD_MUL, 32'd3, 32'd4);
        alu_vec("final_alu", ALU_OR, 32'd8, 32'd1, 32'd9);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage RV32 pipeline; consumes the D/E pipeline register outputs.
- Performs forwarding selection, single-cycle ALU ops, and branch/jump target and decision.
- Contains an iterative RV32M multiply/divide unit whose multi-cycle operation stalls the front of the pipeline.
- Results feed the E/M pipeline register; the branch decision feeds fetch.

Parameters:
XLEN, 32, datapath width (only 32 supported)
ITER, 32, iterations per mul/div operation (equals XLEN)

Ports:
clk  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
RD1E  in  32  register operand 1 from D/E
RD2E  in  32  register operand 2 from D/E
ImmExtE  in  32  extended immediate
PCE  in  32  PC of the instruction in E
ALUControlE  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
ALUSrcE  in  1  1 selects ImmExtE as SrcB
BranchE  in  1  beq instruction
JumpE  in  1  jal instruction
MulDivE  in  1  RV32M instruction in E
MulDivOpE  in  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (0..7)
ForwardAE  in  2  00 RD1E, 01 ResultW, 10 ALUResultM
ForwardBE  in  2  same encoding for operand 2
ResultW  in  32  writeback result
ALUResultM  in  32  memory-stage ALU result
ALUResultE  out  32  ALU or mul/div result
WriteDataE  out  32  forwarded operand 2 (store data)
PCTargetE  out  32  PCE + ImmExtE
PCSrcE  out  1  (BranchE & ZeroE) | JumpE
ZeroE  out  1  ALU result == 0
StallMD  out  1  mul/div busy; hazard unit stalls F, F/D, D/E and bubbles E/M

Behaviour:
- Combinational path:
  - SrcA = fwd(ForwardAE); fwdB = fwd(ForwardBE); SrcB = ALUSrcE ? ImmExtE : fwdB.
  - WriteDataE = fwdB. Encoding 11 selects the register value.
- ALU: add/sub wrap mod 2^32; slt signed, result 0 or 1; undefined codes give 0.
- ALUResultE = ALU result, except in DONE, where it is the latched mul/div result.
- ZeroE and PCSrcE are driven only from the ALU path and forced 0 when MulDivE=1.
- Mul/div FSM states: IDLE, BUSY, DONE.
  - IDLE & MulDivE=1: latch SrcA and fwdB magnitudes plus sign flags; count=0; go BUSY.
  - StallMD=1 combinationally in this issue cycle.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle; count increments.
  - At count==ITER-1, go DONE. StallMD=1 throughout BUSY.
  - DONE: sign-fix applied at the DONE transition; result held in a register; StallMD=0; ALUResultE = result; next state IDLE.
  - The D/E register advances at the end of the DONE cycle, so the same instruction is not re-issued.
- Latency is fixed: issue cycle N, StallMD high N..N+32, result valid in cycle N+33. No early-out.
- Result selection:
  - MUL: low 32 bits of the product.
  - MULH, MULHSU, MULHU: high 32 bits with signed×signed, signed×unsigned, unsigned×unsigned operands.
- Divide by zero:
  - DIV/DIVU quotient = 0xFFFFFFFF.
  - REM/REMU = dividend.
  - Same latency.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF = 0x80000000; REM = 0.
- Remainder sign follows the dividend; quotient is truncated toward zero.
- Operands are latched at issue, so forwarding changes during BUSY have no effect.
- Reset (async, any state, including mid-BUSY):
  - FSM to IDLE; count, operand and result registers to 0.
  - StallMD=0 and ALUResultE reflects the combinational ALU path.
  - The aborted operation is discarded.
- MulDivE=0 while BUSY does not occur, because D/E is frozen; the FSM ignores MulDivE outside IDLE.

Decomposition:
- Package riscv_pkg holds:
  - ALUControl encodings
  - MulDivOp (funct3) encodings
  - forward-select encodings (FWD_REG, FWD_W, FWD_M)
  - muldiv FSM state enum
- Sub-module muldiv_unit:
  - owns the FSM, counter, operand/accumulator registers and sign-fix.
  - ports: clk, reset_n, start, op, a, b, busy, done, result.
- execute_stage keeps the forwarding muxes, ALU and branch logic.

Test Plan:
- ALU and branch: RD1E=5, RD2E=5, ALUControlE=001, BranchE=1, PCE=0x100, ImmExtE=0x20 -> ALUResultE=0, ZeroE=1, PCSrcE=1, PCTargetE=0x120.
- Forwarding: ForwardAE=10, ALUResultM=7; ForwardBE=01, ResultW=3; add -> ALUResultE=10, WriteDataE=3. Repeat with ALUSrcE=1, ImmExtE=1 -> ALUResultE=8.
- MULH: SrcA=0xFFFFFFFF, SrcB=0x00000002 -> StallMD high exactly 33 cycles, then ALUResultE=0xFFFFFFFF for one cycle (MUL gives 0xFFFFFFFE).
- DIV/REM: -7/2 -> quotient 0xFFFFFFFD, REM gives 0xFFFFFFFF. DIVU 7/0 -> 0xFFFFFFFF. REMU 7/0 -> 7. DIV 0x80000000/-1 -> 0x80000000, REM 0.
- Reset mid-operation: start DIVU; deassert reset_n at BUSY cycle 10 -> StallMD=0 immediately, FSM IDLE. After release, a new MUL 3×4 returns 12 after 33 stall cycles.
- Back-to-back: MUL followed by DIV in consecutive instructions -> two separate 33-cycle stalls, each result valid for one DONE cycle, no lost or duplicated results.
